// File: rtl/sample_pkg.sv
// Shared definitions for the sample pairer: phase encoding and default sizes.
package sample_pkg;

  // PH_LO: no half-pair held; PH_HI: low half waiting in lo_reg
  typedef enum logic {
    PH_LO = 1'b0,
    PH_HI = 1'b1
  } phase_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through FIFO with occupancy output. A push while full is
// accepted only when a pop frees the head slot in the same cycle.
import sample_pkg::*;

module sample_fifo #(
  parameter int WIDTH = 2 * DEF_WIDTH + 1,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_valid,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_pop;
  logic             w_push_ok;

  assign o_valid   = (r_level != '0);
  assign o_full    = (r_level == FULL_LVL);
  assign o_level   = r_level;
  assign w_pop     = i_pop && o_valid;
  // When full, the write slot equals the head slot being popped this cycle
  assign w_push_ok = i_push && (!o_full || w_pop);
  // Head is zeroed when empty so nothing stale is presented
  assign o_rdata   = o_valid ? r_mem[r_rptr] : '0;

  // Storage array; data only, no reset needed
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/sample_pairer.sv
// Packs consecutive samples into {second, first} words and queues them in a
// FWFT FIFO. Flush forces out a lone sample as an odd word with upper half zero.
import sample_pkg::*;

module sample_pairer #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  input  logic                     flush,
  output logic [2*WIDTH-1:0]       out_data,
  output logic                     out_odd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int FW = 2 * WIDTH + 1;

  phase_t           r_phase;
  phase_t           w_phase_nxt;
  logic [WIDTH-1:0] r_lo;
  logic             r_ovf;
  logic             w_push;
  logic [FW-1:0]    w_push_word;
  logic             w_capture;
  logic [FW-1:0]    w_head;
  logic             w_full;
  logic             w_pop;
  logic             w_drop;

  // Pairing decision: at most one push per cycle, full pair beats flush
  always_comb begin
    w_push      = 1'b0;
    w_push_word = '0;
    w_capture   = 1'b0;
    w_phase_nxt = r_phase;
    if (in_valid) begin
      if (r_phase == PH_HI) begin
        w_push      = 1'b1;
        w_push_word = {1'b0, in_data, r_lo};
        w_phase_nxt = PH_LO;
      end else if (flush) begin
        w_push      = 1'b1;
        w_push_word = {1'b1, {WIDTH{1'b0}}, in_data};
      end else begin
        w_capture   = 1'b1;
        w_phase_nxt = PH_HI;
      end
    end else if (flush && r_phase == PH_HI) begin
      w_push      = 1'b1;
      w_push_word = {1'b1, {WIDTH{1'b0}}, r_lo};
      w_phase_nxt = PH_LO;
    end
  end

  assign w_pop  = out_valid && out_ready;
  assign w_drop = w_push && w_full && !w_pop;

  // Phase, held low half and sticky overflow; a drop outranks clr_ovf
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= PH_LO;
      r_lo    <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      if (w_capture) r_lo <= in_data;
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  sample_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_push_word),
    .i_pop   (out_ready),
    .o_rdata (w_head),
    .o_valid (out_valid),
    .o_full  (w_full),
    .o_level (level)
  );

  assign out_data = w_head[2*WIDTH-1:0];
  assign out_odd  = w_head[2*WIDTH];
  assign overflow = r_ovf;

endmodule

// File: tb/tb_sample_pairer.sv
// Directed bench for sample_pairer with WIDTH=16, DEPTH=4.
module tb_sample_pairer;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        flush;
  logic [31:0] out_data;
  logic        out_odd;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic        clr_ovf;
  logic [2:0]  level;

  int n_tests;
  int n_fail;

  sample_pairer #(.WIDTH(16), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .flush     (flush),
    .out_data  (out_data),
    .out_odd   (out_odd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
    clr_ovf  = 1'b0;
    in_data  = 16'h0000;
  endtask

  task automatic sample(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
  endtask

  function automatic logic [31:0] pair_word(input int k);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = 16'h1000 + 16'(k);
    hi = 16'h2000 + 16'(k);
    return {hi, lo};
  endfunction

  // Push pair k over two cycles; ready/clr applied only on the second sample
  task automatic push_pair(input int k, input logic rdy2, input logic clr2);
    sample(16'h1000 + 16'(k));
    out_ready = 1'b0;
    tick();
    sample(16'h2000 + 16'(k));
    out_ready = rdy2;
    clr_ovf   = clr2;
    tick();
    idle();
    out_ready = 1'b0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    idle();
    repeat (3) tick();

    // Reset state
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_level", 64'(level), 64'h0);
    chk("rst_ovf", 64'(overflow), 64'h0);
    chk("rst_data", 64'(out_data), 64'h0);
    chk("rst_odd", 64'(out_odd), 64'h0);
    rst_n = 1'b1;
    tick();

    // Basic pair
    out_ready = 1'b1;
    sample(16'h1111);
    tick();
    chk("pair_no_early_valid", 64'(out_valid), 64'h0);
    sample(16'h2222);
    tick();
    idle();
    chk("pair_valid", 64'(out_valid), 64'h1);
    chk("pair_data", 64'(out_data), 64'h22221111);
    chk("pair_odd", 64'(out_odd), 64'h0);
    tick();
    chk("pair_popped", 64'(out_valid), 64'h0);

    // Single sample then flush
    sample(16'hABCD);
    out_ready = 1'b0;
    tick();
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_data", 64'(out_data), 64'h0000ABCD);
    chk("flush_odd", 64'(out_odd), 64'h1);
    chk("flush_level", 64'(level), 64'h1);
    out_ready = 1'b1;
    tick();
    chk("flush_drained", 64'(out_valid), 64'h0);
    // Phase back in PH_LO: next two samples form an aligned pair
    sample(16'h0003);
    tick();
    sample(16'h0004);
    tick();
    idle();
    chk("flush_realign", 64'(out_data), 64'h00040003);
    chk("flush_realign_odd", 64'(out_odd), 64'h0);
    tick();

    // Flush with in_valid in PH_LO
    flush = 1'b1;
    sample(16'h00FF);
    tick();
    idle();
    chk("fl_lo_data", 64'(out_data), 64'h000000FF);
    chk("fl_lo_odd", 64'(out_odd), 64'h1);
    chk("fl_lo_level", 64'(level), 64'h1);
    tick();
    chk("fl_lo_single", 64'(out_valid), 64'h0);
    out_ready = 1'b0;

    // Overflow: five pairs into depth four, then a drop together with clr_ovf
    for (int k = 1; k <= 5; k++) push_pair(k, 1'b0, 1'b0);
    chk("ovf_level", 64'(level), 64'h4);
    chk("ovf_flag", 64'(overflow), 64'h1);
    chk("ovf_stable_head", 64'(out_data), 64'(pair_word(1)));
    push_pair(6, 1'b0, 1'b1);
    chk("ovf_drop_beats_clr", 64'(overflow), 64'h1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", 64'(overflow), 64'h0);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_drain%0d", k), 64'(out_data), 64'(pair_word(k)));
      tick();
    end
    chk("ovf_drain_empty", 64'(out_valid), 64'h0);
    out_ready = 1'b0;

    // Full FIFO with simultaneous push and pop
    for (int k = 11; k <= 14; k++) push_pair(k, 1'b0, 1'b0);
    chk("fp_full", 64'(level), 64'h4);
    push_pair(15, 1'b1, 1'b0);
    chk("fp_level", 64'(level), 64'h4);
    chk("fp_ovf", 64'(overflow), 64'h0);
    out_ready = 1'b1;
    for (int k = 12; k <= 15; k++) begin
      chk($sformatf("fp_drain%0d", k), 64'(out_data), 64'(pair_word(k)));
      tick();
    end
    chk("fp_empty", 64'(level), 64'h0);

    // Reset mid-pair discards the held sample
    sample(16'h5555);
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_level", 64'(level), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    sample(16'h0001);
    tick();
    chk("post_rst_no_partial", 64'(out_valid), 64'h0);
    sample(16'h0002);
    tick();
    idle();
    chk("post_rst_data", 64'(out_data), 64'h00020001);
    chk("post_rst_odd", 64'(out_odd), 64'h0);
    tick();
    chk("post_rst_empty", 64'(out_valid), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_pairer.md
SAMPLE_PAIRER -- requirements
Module: sample_pairer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the width of one input sample.
REQ-002 SHALL have parameter DEPTH, default 4, the number of output FIFO entries (power of two, at least 2).
REQ-003 SHALL have port clk  input  1  the single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_data  input  WIDTH  the incoming sample.
REQ-006 SHALL have port in_valid  input  1  in_data is valid this cycle; there is no backpressure.
REQ-007 SHALL have port flush  input  1  force out any half-filled pair.
REQ-008 SHALL have port out_data  output  2*WIDTH  packed pair {second sample, first sample}.
REQ-009 SHALL have port out_odd  output  1  the head word holds one sample only (upper half zero).
REQ-010 SHALL have port out_valid  output  1  the FIFO head is valid.
REQ-011 SHALL have port out_ready  input  1  the consumer accepts the head when out_valid is also high.
REQ-012 SHALL have port overflow  output  1  sticky flag: a pair was dropped.
REQ-013 SHALL have port clr_ovf  input  1  clear overflow.
REQ-014 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 SHALL hold a phase bit: PH_LO (no half held) and PH_HI (low half held in lo_reg).
REQ-016 SHALL, in PH_LO with in_valid, capture in_data into lo_reg and go to PH_HI.
REQ-017 SHALL, in PH_HI with in_valid, push {in_data, lo_reg} with odd=0 and go to PH_LO.
REQ-018 SHALL, on flush in PH_HI without in_valid, push {0, lo_reg} with odd=1 and go to PH_LO.
REQ-019 SHALL, on flush in PH_LO with in_valid, push {0, in_data} with odd=1 and stay in PH_LO.
REQ-020 SHALL, on flush in PH_HI with in_valid, push the full pair per REQ-017; flush then adds no second push.
REQ-021 SHALL treat flush in PH_LO without in_valid as a no-op.
REQ-022 SHALL perform at most one push per cycle.
REQ-023 SHALL have first-word-fall-through output: out_valid rises in the cycle after the push edge; push-to-out_valid latency is one clock.
REQ-024 SHALL pop on out_valid AND out_ready; out_data and out_odd SHALL remain stable while out_valid is high and out_ready is low.
REQ-025 SHALL, on a push with level==DEPTH and no pop, drop the pair, leave the FIFO contents unchanged and set overflow.
REQ-026 SHALL accept a push when full if a pop occurs the same cycle; level is then unchanged.
REQ-027 SHALL leave level unchanged on a simultaneous push and pop when not full.
REQ-028 SHALL wrap read and write pointers modulo DEPTH.
REQ-029 SHALL clear overflow on clr_ovf; a drop in the same cycle as clr_ovf SHALL win and set overflow.
REQ-030 SHALL ignore in_data when in_valid is low.

Reset
REQ-031 SHALL, while rst_n is low, asynchronously force phase=PH_LO, level=0, pointers=0, out_valid=0, out_odd=0, overflow=0, out_data=0, lo_reg=0.
REQ-032 SHALL discard a half-held sample when reset asserts mid-pair; no partial word SHALL appear after reset.
REQ-033 SHALL have the first in_valid after rst_n deasserts land in the low half.

Structure
REQ-034 SHALL place the phase encoding (PH_LO, PH_HI) and the default WIDTH/DEPTH constants in the shared package sample_pkg.
REQ-035 SHALL implement storage as one sub-module, sample_fifo (FWFT, parameterized width and depth, with level output); the pairing logic stays in sample_pairer.

Verification
REQ-036 SHALL check: WIDTH=16; in_valid for 2 cycles with 0x1111 then 0x2222; out_ready=1 -> out_data=0x22221111, out_odd=0, out_valid one cycle after the second sample.
REQ-037 SHALL check: single sample 0xABCD, then flush -> out_data=0x0000ABCD, out_odd=1; phase returns to PH_LO.
REQ-038 SHALL check: out_ready=0 with 5 pairs pushed (DEPTH=4) -> level=4, overflow=1, then drain yields exactly the first 4 pairs in order.
REQ-039 SHALL check: full FIFO, push and pop in the same cycle -> level stays 4, overflow stays 0, the new pair appears last.
REQ-040 SHALL check: rst_n pulsed low after one sample 0x5555, then samples 0x0001 and 0x0002 -> out_data=0x00020001; 0x5555 never appears.
REQ-041 SHALL check: flush and in_valid together in PH_LO with 0x00FF -> a single word 0x000000FF, out_odd=1.
